// File: rtl/cmos_arbiter.sv
// Arbitrates Z80-side and AVR-side accesses onto one shared CMOS store port.
// Latency: strobe at E0, grant at E1, ack high in the cycle after E3 (3-cycle transfer, 1 idle between).
// Backpressure: one pending request per side; strobes arriving while that side is pending are dropped.
module cmos_arbiter #(
   parameter bit Z_FIXED_PRIO = 1'b0
) (
   input  logic       zclk,
   input  logic       rst_n,
   input  logic       z_stb,
   input  logic [7:0] z_addr,
   input  logic       z_rnw,
   input  logic [7:0] z_wdata,
   output logic       z_ack,
   output logic [7:0] z_rdata,
   input  logic       a_stb,
   input  logic [7:0] a_addr,
   input  logic       a_rnw,
   input  logic [7:0] a_wdata,
   output logic       a_ack,
   output logic [7:0] a_rdata,
   output logic       cmos_req,
   output logic [7:0] cmos_addr,
   output logic       cmos_rnw,
   output logic [7:0] cmos_write,
   input  logic [7:0] cmos_read,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;

   state_t     state;
   logic       last_avr;   // 1 = AVR side holds (or last held) the grant
   logic       z_pend, a_pend;
   logic [7:0] z_addr_q, z_wdata_q, a_addr_q, a_wdata_q;
   logic       z_rnw_q, a_rnw_q;
   logic       z_clr, a_clr, gnt_avr;

   // last_avr only moves on a grant, so during HOLD it names the side being served
   assign z_clr = (state == HOLD) && !last_avr;
   assign a_clr = (state == HOLD) &&  last_avr;

   // AVR wins if it is the only requester, or on a round-robin tie when Z80 went last
   assign gnt_avr = a_pend && (!z_pend || (!Z_FIXED_PRIO && !last_avr));

   // Z80 pending bit and request capture; a new strobe on the clearing edge wins
   always_ff @(posedge zclk or negedge rst_n) begin
      if (!rst_n) begin
         z_pend    <= 1'b0;
         z_addr_q  <= 8'h00;
         z_rnw_q   <= 1'b1;
         z_wdata_q <= 8'h00;
      end else if (z_stb && (!z_pend || z_clr)) begin
         z_pend    <= 1'b1;
         z_addr_q  <= z_addr;
         z_rnw_q   <= z_rnw;
         z_wdata_q <= z_wdata;
      end else if (z_clr) begin
         z_pend    <= 1'b0;
      end
   end

   // AVR pending bit and request capture; a new strobe on the clearing edge wins
   always_ff @(posedge zclk or negedge rst_n) begin
      if (!rst_n) begin
         a_pend    <= 1'b0;
         a_addr_q  <= 8'h00;
         a_rnw_q   <= 1'b1;
         a_wdata_q <= 8'h00;
      end else if (a_stb && (!a_pend || a_clr)) begin
         a_pend    <= 1'b1;
         a_addr_q  <= a_addr;
         a_rnw_q   <= a_rnw;
         a_wdata_q <= a_wdata;
      end else if (a_clr) begin
         a_pend    <= 1'b0;
      end
   end

   // Transfer FSM: grant and drive the store, wait for its registered read, then ack the owner
   always_ff @(posedge zclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         cmos_req   <= 1'b0;
         cmos_addr  <= 8'h00;
         cmos_rnw   <= 1'b1;
         cmos_write <= 8'h00;
         last_avr   <= 1'b1;
         z_ack      <= 1'b0;
         a_ack      <= 1'b0;
         z_rdata    <= 8'h00;
         a_rdata    <= 8'h00;
      end else begin
         z_ack <= 1'b0;
         a_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (z_pend || a_pend) begin
                  state      <= ISSUE;
                  busy       <= 1'b1;
                  cmos_req   <= 1'b1;
                  last_avr   <= gnt_avr;
                  cmos_addr  <= gnt_avr ? a_addr_q  : z_addr_q;
                  cmos_rnw   <= gnt_avr ? a_rnw_q   : z_rnw_q;
                  cmos_write <= gnt_avr ? a_wdata_q : z_wdata_q;
               end
            end
            ISSUE: begin
               state    <= HOLD;
               cmos_req <= 1'b0;
            end
            HOLD: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (last_avr) begin
                  a_rdata <= cmos_read;
                  a_ack   <= 1'b1;
               end else begin
                  z_rdata <= cmos_read;
                  z_ack   <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               cmos_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmos_arbiter.sv
// Directed bench: round-robin instance dut0 and fixed-priority instance dut1 share all inputs,
// each with its own behavioural CMOS store (registered read, 0xF0-0xFF reads 0xFF, writes ignored there).
module tb_cmos_arbiter;

   logic       zclk, rst_n;
   logic       z_stb, z_rnw, a_stb, a_rnw;
   logic [7:0] z_addr, z_wdata, a_addr, a_wdata;

   logic       z_ack0, a_ack0, cmos_req0, cmos_rnw0, busy0;
   logic [7:0] z_rdata0, a_rdata0, cmos_addr0, cmos_write0, cmos_read0;
   logic       z_ack1, a_ack1, cmos_req1, cmos_rnw1, busy1;
   logic [7:0] z_rdata1, a_rdata1, cmos_addr1, cmos_write1, cmos_read1;

   logic [7:0] mem0 [256];
   logic [7:0] mem1 [256];

   int n_cmp = 0;
   int n_err = 0;
   int zack0 = 0, aack0 = 0, zack1 = 0, aack1 = 0;

   cmos_arbiter #(.Z_FIXED_PRIO(1'b0)) dut0 (
      .zclk(zclk), .rst_n(rst_n),
      .z_stb(z_stb), .z_addr(z_addr), .z_rnw(z_rnw), .z_wdata(z_wdata), .z_ack(z_ack0), .z_rdata(z_rdata0),
      .a_stb(a_stb), .a_addr(a_addr), .a_rnw(a_rnw), .a_wdata(a_wdata), .a_ack(a_ack0), .a_rdata(a_rdata0),
      .cmos_req(cmos_req0), .cmos_addr(cmos_addr0), .cmos_rnw(cmos_rnw0), .cmos_write(cmos_write0),
      .cmos_read(cmos_read0), .busy(busy0));

   cmos_arbiter #(.Z_FIXED_PRIO(1'b1)) dut1 (
      .zclk(zclk), .rst_n(rst_n),
      .z_stb(z_stb), .z_addr(z_addr), .z_rnw(z_rnw), .z_wdata(z_wdata), .z_ack(z_ack1), .z_rdata(z_rdata1),
      .a_stb(a_stb), .a_addr(a_addr), .a_rnw(a_rnw), .a_wdata(a_wdata), .a_ack(a_ack1), .a_rdata(a_rdata1),
      .cmos_req(cmos_req1), .cmos_addr(cmos_addr1), .cmos_rnw(cmos_rnw1), .cmos_write(cmos_write1),
      .cmos_read(cmos_read1), .busy(busy1));

   initial begin
      zclk = 1'b0;
      forever #5 zclk = ~zclk;
   end

   // Store models: read registered one edge after the address, write committed on the edge after cmos_req
   always @(posedge zclk) begin
      cmos_read0 <= (cmos_addr0 >= 8'hF0) ? 8'hFF : mem0[cmos_addr0];
      if (cmos_req0 && !cmos_rnw0 && cmos_addr0 < 8'hF0) mem0[cmos_addr0] <= cmos_write0;
      cmos_read1 <= (cmos_addr1 >= 8'hF0) ? 8'hFF : mem1[cmos_addr1];
      if (cmos_req1 && !cmos_rnw1 && cmos_addr1 < 8'hF0) mem1[cmos_addr1] <= cmos_write1;
   end

   // Ack pulse counters
   always @(posedge zclk) begin
      if (z_ack0) zack0 <= zack0 + 1;
      if (a_ack0) aack0 <= aack0 + 1;
      if (z_ack1) zack1 <= zack1 + 1;
      if (a_ack1) aack1 <= aack1 + 1;
   end

   task automatic tick();
      @(posedge zclk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic z_req(input logic [7:0] ad, input logic rw, input logic [7:0] wd);
      z_addr = ad; z_rnw = rw; z_wdata = wd; z_stb = 1'b1;
      tick();
      z_stb = 1'b0;
   endtask

   task automatic a_req(input logic [7:0] ad, input logic rw, input logic [7:0] wd);
      a_addr = ad; a_rnw = rw; a_wdata = wd; a_stb = 1'b1;
      tick();
      a_stb = 1'b0;
   endtask

   task automatic test_reset();
      z_stb = 0; a_stb = 0; z_rnw = 1; a_rnw = 1;
      z_addr = 0; a_addr = 0; z_wdata = 0; a_wdata = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      n_cmp++; if (cmos_req0 !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", cmos_req0); end
      n_cmp++; if (cmos_rnw0 !== 1'b1) begin n_err++; $display("FAIL reset_rnw got=%b exp=1", cmos_rnw0); end
      n_cmp++; if (cmos_addr0 !== 8'h00) begin n_err++; $display("FAIL reset_addr got=%h exp=00", cmos_addr0); end
      n_cmp++; if (cmos_write0 !== 8'h00) begin n_err++; $display("FAIL reset_wdata got=%h exp=00", cmos_write0); end
      n_cmp++; if ({z_ack0, a_ack0} !== 2'b00) begin n_err++; $display("FAIL reset_ack got=%b exp=00", {z_ack0, a_ack0}); end
      n_cmp++; if ({z_rdata0, a_rdata0} !== 16'h0000) begin n_err++; $display("FAIL reset_rdata got=%h exp=0000", {z_rdata0, a_rdata0}); end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL idle_after_reset got=%b exp=0", busy0); end
   endtask

   task automatic test_write_read();
      z_req(8'h10, 1'b0, 8'h5A);                       // E0
      tick();                                          // E1: grant
      n_cmp++; if (cmos_req0 !== 1'b1) begin n_err++; $display("FAIL wr_req got=%b exp=1", cmos_req0); end
      n_cmp++; if ({cmos_addr0, cmos_rnw0, cmos_write0} !== {8'h10, 1'b0, 8'h5A})
         begin n_err++; $display("FAIL wr_cmd got=%h/%b/%h exp=10/0/5a", cmos_addr0, cmos_rnw0, cmos_write0); end
      n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL wr_busy got=%b exp=1", busy0); end
      tick();                                          // E2
      n_cmp++; if (cmos_req0 !== 1'b0) begin n_err++; $display("FAIL wr_req_pulse got=%b exp=0", cmos_req0); end
      n_cmp++; if (z_ack0 !== 1'b0) begin n_err++; $display("FAIL wr_early_ack got=%b exp=0", z_ack0); end
      tick();                                          // E3
      n_cmp++; if (z_ack0 !== 1'b1) begin n_err++; $display("FAIL wr_ack got=%b exp=1", z_ack0); end
      n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL wr_busy_end got=%b exp=0", busy0); end
      tick();                                          // E4
      n_cmp++; if (z_ack0 !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse got=%b exp=0", z_ack0); end
      z_req(8'h10, 1'b1, 8'h00);
      tick();
      n_cmp++; if ({cmos_req0, cmos_rnw0, cmos_addr0} !== {1'b1, 1'b1, 8'h10})
         begin n_err++; $display("FAIL rd_cmd got=%b/%b/%h exp=1/1/10", cmos_req0, cmos_rnw0, cmos_addr0); end
      tick();
      tick();
      n_cmp++; if (z_ack0 !== 1'b1) begin n_err++; $display("FAIL rd_ack got=%b exp=1", z_ack0); end
      n_cmp++; if (z_rdata0 !== 8'h5A) begin n_err++; $display("FAIL rd_data got=%h exp=5a", z_rdata0); end
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      z_addr = 8'h20; z_rnw = 1; a_addr = 8'h21; a_rnw = 1; z_stb = 1; a_stb = 1;
      tick();                                          // E0
      z_stb = 0; a_stb = 0;
      tick();                                          // E1
      n_cmp++; if (cmos_addr0 !== 8'h20) begin n_err++; $display("FAIL rr_first got=%h exp=20", cmos_addr0); end
      n_cmp++; if (cmos_addr1 !== 8'h20) begin n_err++; $display("FAIL fp_first got=%h exp=20", cmos_addr1); end
      tick();                                          // E2
      z_addr = 8'h22; a_addr = 8'h23; z_stb = 1; a_stb = 1;
      tick();                                          // E3: Z ack edge, both strobe again
      z_stb = 0; a_stb = 0;
      n_cmp++; if ({z_ack0, a_ack0} !== 2'b10) begin n_err++; $display("FAIL rr_ack1 got=%b exp=10", {z_ack0, a_ack0}); end
      tick();                                          // E4
      n_cmp++; if (cmos_addr0 !== 8'h21) begin n_err++; $display("FAIL rr_avr_second got=%h exp=21", cmos_addr0); end
      n_cmp++; if (cmos_addr1 !== 8'h22) begin n_err++; $display("FAIL fp_z_again got=%h exp=22", cmos_addr1); end
      tick();
      tick();                                          // E6
      n_cmp++; if (a_ack0 !== 1'b1) begin n_err++; $display("FAIL rr_ack2 got=%b exp=1", a_ack0); end
      n_cmp++; if (z_ack1 !== 1'b1) begin n_err++; $display("FAIL fp_ack2 got=%b exp=1", z_ack1); end
      tick();                                          // E7
      n_cmp++; if (cmos_addr0 !== 8'h22) begin n_err++; $display("FAIL rr_third got=%h exp=22", cmos_addr0); end
      n_cmp++; if (cmos_addr1 !== 8'h21) begin n_err++; $display("FAIL fp_third got=%h exp=21", cmos_addr1); end
      tick();
      tick();
      n_cmp++; if ({z_ack0, a_ack1} !== 2'b11) begin n_err++; $display("FAIL rr_ack3 got=%b exp=11", {z_ack0, a_ack1}); end
      tick();
   endtask

   task automatic test_fixed_prio();
      int zb, ab;
      do_reset();
      zb = zack1; ab = aack1;
      z_addr = 8'h70; z_rnw = 1; a_addr = 8'h71; a_rnw = 1; z_stb = 1; a_stb = 1;
      for (int i = 0; i < 12; i++) tick();             // E0..E11 with both strobing
      z_stb = 0; a_stb = 0;
      tick();                                          // E12
      n_cmp++; if (zack1 - zb !== 3) begin n_err++; $display("FAIL fp_z_count got=%0d exp=3", zack1 - zb); end
      n_cmp++; if (aack1 - ab !== 0) begin n_err++; $display("FAIL fp_a_starved got=%0d exp=0", aack1 - ab); end
      tick();                                          // E13
      n_cmp++; if ({cmos_req1, cmos_addr1} !== {1'b1, 8'h71})
         begin n_err++; $display("FAIL fp_a_grant got=%b/%h exp=1/71", cmos_req1, cmos_addr1); end
      tick(); tick(); tick();                          // E16
      n_cmp++; if ({zack1 - zb, aack1 - ab} !== {32'd4, 32'd1})
         begin n_err++; $display("FAIL fp_totals got=%0d/%0d exp=4/1", zack1 - zb, aack1 - ab); end
   endtask

   task automatic test_reserved();
      a_req(8'hF5, 1'b1, 8'h00);
      tick();
      n_cmp++; if (cmos_addr0 !== 8'hF5) begin n_err++; $display("FAIL rsv_fwd got=%h exp=f5", cmos_addr0); end
      tick(); tick();
      n_cmp++; if (a_rdata0 !== 8'hFF) begin n_err++; $display("FAIL rsv_read got=%h exp=ff", a_rdata0); end
      tick();
      a_req(8'hF5, 1'b0, 8'h00);
      tick(); tick(); tick(); tick();
      a_req(8'hF5, 1'b1, 8'h00);
      tick(); tick(); tick();
      n_cmp++; if ({a_ack0, a_rdata0} !== {1'b1, 8'hFF}) begin n_err++; $display("FAIL rsv_after_write got=%b/%h exp=1/ff", a_ack0, a_rdata0); end
      tick();
   endtask

   task automatic test_ignore();
      int zb;
      zb = zack0;
      a_req(8'h50, 1'b1, 8'h00);                       // E0
      z_addr = 8'h10; z_rnw = 1; z_stb = 1;
      tick();                                          // E1: A granted, Z pending
      n_cmp++; if (cmos_addr0 !== 8'h50) begin n_err++; $display("FAIL ign_a_grant got=%h exp=50", cmos_addr0); end
      z_addr = 8'h40;
      tick();                                          // E2: second Z strobe must be dropped
      z_stb = 0;
      tick();                                          // E3
      tick();                                          // E4
      n_cmp++; if (cmos_addr0 !== 8'h10) begin n_err++; $display("FAIL ign_latched got=%h exp=10", cmos_addr0); end
      tick();                                          // E5
      z_addr = 8'h11; z_rnw = 0; z_wdata = 8'h33; z_stb = 1;
      tick();                                          // E6: ack edge, new strobe accepted
      z_stb = 0;
      n_cmp++; if ({z_ack0, z_rdata0} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL ign_ack got=%b/%h exp=1/5a", z_ack0, z_rdata0); end
      tick();                                          // E7
      n_cmp++; if ({cmos_req0, cmos_addr0, cmos_rnw0, cmos_write0} !== {1'b1, 8'h11, 1'b0, 8'h33})
         begin n_err++; $display("FAIL ign_new_req got=%b/%h/%b/%h exp=1/11/0/33", cmos_req0, cmos_addr0, cmos_rnw0, cmos_write0); end
      tick(); tick(); tick();                          // E10
      n_cmp++; if (zack0 - zb !== 2) begin n_err++; $display("FAIL ign_ack_count got=%0d exp=2", zack0 - zb); end
   endtask

   task automatic test_reset_mid();
      int zb;
      zb = zack0;
      z_req(8'h60, 1'b0, 8'hAB);                       // E0
      tick();                                          // E1: ISSUE
      tick();                                          // E2: HOLD
      n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL mid_in_hold got=%b exp=1", busy0); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({cmos_req0, z_ack0, busy0} !== 3'b000)
         begin n_err++; $display("FAIL mid_abort got=%b exp=000", {cmos_req0, z_ack0, busy0}); end
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick(); tick();
      n_cmp++; if ({busy0, cmos_req0} !== 2'b00) begin n_err++; $display("FAIL mid_no_replay got=%b exp=00", {busy0, cmos_req0}); end
      n_cmp++; if (zack0 - zb !== 0) begin n_err++; $display("FAIL mid_no_ack got=%0d exp=0", zack0 - zb); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_fixed_prio();
      test_reserved();
      test_ignore();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cmos_arbiter.md
CMOS_ARBITER -- requirements
Module: cmos_arbiter

Interface
REQ-001 Parameter: Z_FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = Z80 side always wins a tie.
REQ-002 zclk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 z_stb  in  1  Z80-side access strobe, one-cycle pulse.
REQ-005 z_addr  in  8  Z80-side CMOS address, valid with z_stb.
REQ-006 z_rnw  in  1  Z80-side direction, 1 = read, 0 = write, valid with z_stb.
REQ-007 z_wdata  in  8  Z80-side write data, valid with z_stb.
REQ-008 z_ack  out  1  Z80-side completion pulse, one cycle.
REQ-009 z_rdata  out  8  Z80-side read data, updated with z_ack.
REQ-010 a_stb, a_addr, a_rnw, a_wdata, a_ack, a_rdata: AVR-side port, same widths and meaning as REQ-004..REQ-009.
REQ-011 cmos_req  out  1  access pulse to CMOS store.
REQ-012 cmos_addr  out  8  CMOS address.
REQ-013 cmos_rnw  out  1  CMOS direction.
REQ-014 cmos_write  out  8  CMOS write data.
REQ-015 cmos_read  in  8  CMOS read data, registered by the store one edge after cmos_addr.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Each side SHALL have a pending bit plus latched addr/rnw/wdata; z_stb/a_stb SHALL set it and capture the inputs only when pending is 0 or is being cleared at that same edge (set wins); a strobe while pending stays set SHALL be ignored.
REQ-018 FSM states: IDLE, ISSUE, HOLD; IDLE->ISSUE when any pending bit is 1; ISSUE->HOLD unconditionally; HOLD->IDLE unconditionally.
REQ-019 On IDLE->ISSUE the granted side's latched addr/rnw/wdata SHALL load cmos_addr/cmos_rnw/cmos_write, and cmos_req SHALL be 1 for exactly the ISSUE cycle.
REQ-020 cmos_addr/cmos_rnw/cmos_write SHALL stay constant from grant until the next grant; the store commits the write one edge after cmos_req, within HOLD.
REQ-021 On HOLD->IDLE the granted side's rdata SHALL capture cmos_read (for writes too), its ack SHALL pulse for one cycle, and its pending bit SHALL clear.
REQ-022 Latency: strobe sampled at edge E0 -> grant at E1 -> ack high in the cycle after E3; one transfer per 3 cycles minimum, one idle cycle between transfers.
REQ-023 Arbitration when both pending: Z_FIXED_PRIO=1 -> Z80 side; Z_FIXED_PRIO=0 -> side not granted last; last-grant register SHALL flip only on grant.
REQ-024 Single requester pending SHALL be granted regardless of last-grant.
REQ-025 Addresses 0xF0-0xFF SHALL be forwarded unchanged; the store returns 0xFF and ignores writes.
REQ-026 z_rdata/a_rdata SHALL hold their value until that side's next ack.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, cmos_req 0, z_ack/a_ack 0, busy 0, pending bits 0, cmos_addr 0x00, cmos_rnw 1, cmos_write 0x00, z_rdata/a_rdata 0x00, last-grant = AVR side (Z80 wins first tie).
REQ-028 Reset asserted mid-transfer (ISSUE or HOLD) SHALL abort it without ack; the transfer is lost and not replayed after release.

Verification
REQ-029 z_stb write addr 0x10 data 0x5A, then z_stb read 0x10 -> cmos_req one-cycle pulses, z_ack 3 cycles after each strobe, z_rdata=0x5A.
REQ-030 z_stb and a_stb same edge, Z_FIXED_PRIO=0, after reset -> Z80 granted first, AVR granted at the next IDLE; repeat both -> AVR granted first.
REQ-031 Z_FIXED_PRIO=1, both sides strobing continuously -> Z80 granted every transfer, AVR granted only when Z80 has no pending request.
REQ-032 a_stb read 0xF5 -> a_rdata=0xFF; a_stb write 0xF5 data 0x00 then read -> still 0xFF.
REQ-033 Second z_stb while Z80 pending -> ignored, only one z_ack; z_stb in the ack-edge cycle -> accepted as new request.
REQ-034 rst_n pulled low in HOLD of a write -> cmos_req 0, no ack, busy 0 immediately; after release, IDLE with no pending request.
